wb_port_arbiter: RTL and testbench

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

---
 rtl/wb_port_arbiter_if.sv | 30 +++
 rtl/wb_port_arbiter.sv | 122 ++++++++++++
 tb/tb_wb_port_arbiter.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/wb_port_arbiter_if.sv
// Register-file write port bundle shared by the W-stage pipeline, the MDU result path,
// and the hazard-query lines. The arbiter attaches through the slave modport.
interface wb_port_arbiter_if;
    logic        RegWriteW;
    logic [4:0]  RdW;
    logic [31:0] ResultW;
    logic        MduValid;
    logic [4:0]  MduRd;
    logic [31:0] MduData;
    logic        MduReady;
    logic [4:0]  Rs1Q;
    logic [4:0]  Rs2Q;
    logic        PendHit1;
    logic        PendHit2;
    logic        RegWriteRF;
    logic [4:0]  RdRF;
    logic [31:0] WDataRF;
    logic [2:0]  BufCount;
    logic        StarveStall;

    modport master (
        output RegWriteW, RdW, ResultW, MduValid, MduRd, MduData, Rs1Q, Rs2Q,
        input  MduReady, PendHit1, PendHit2, RegWriteRF, RdRF, WDataRF, BufCount, StarveStall
    );

    modport slave (
        input  RegWriteW, RdW, ResultW, MduValid, MduRd, MduData, Rs1Q, Rs2Q,
        output MduReady, PendHit1, PendHit2, RegWriteRF, RdRF, WDataRF, BufCount, StarveStall
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// Shares the single register-file write port between the W stage and a multi-cycle unit.
// The pipeline always wins; MDU results bypass when idle or queue in a small FIFO otherwise.
module wb_port_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic         clk,
    input  logic         reset,
    wb_port_arbiter_if.slave bus
);

    localparam int             PW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [2:0]     DEPTH_CNT  = 3'(DEPTH);
    localparam logic [2:0]     STARVE_AGE = 3'(STARVE_LIMIT);
    localparam logic [PW-1:0]  LAST_PTR   = PW'(DEPTH - 1);

    logic [4:0]       entryRd   [DEPTH];
    logic [31:0]      entryData [DEPTH];
    logic [DEPTH-1:0] entryValid;
    logic [PW-1:0]    headPtr;
    logic [PW-1:0]    tailPtr;
    logic [2:0]       count;
    logic [2:0]       age;

    logic             pipeLive;
    logic             mduReady;
    logic             accept;
    logic             mduLive;
    logic             bypass;
    logic             drain;
    logic             enqueue;
    logic [DEPTH-1:0] hit1Vec;
    logic [DEPTH-1:0] hit2Vec;

    function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // Writes to x0 are architecturally void, so they never claim the port.
    always_comb begin
        pipeLive = bus.RegWriteW && (bus.RdW != 5'd0);
        mduReady = (count < DEPTH_CNT) && !reset;
        accept   = bus.MduValid && mduReady;
        mduLive  = accept && (bus.MduRd != 5'd0);
        drain    = !pipeLive && (count != 3'd0);
        bypass   = mduLive && !pipeLive && (count == 3'd0);
        enqueue  = mduLive && !bypass;
    end

    // Port ownership priority: live pipeline write, then the FIFO head, then a bypass.
    always_comb begin
        bus.RegWriteRF = 1'b0;
        bus.RdRF       = 5'd0;
        bus.WDataRF    = 32'd0;
        if (pipeLive) begin
            bus.RegWriteRF = 1'b1;
            bus.RdRF       = bus.RdW;
            bus.WDataRF    = bus.ResultW;
        end else if (drain) begin
            bus.RegWriteRF = 1'b1;
            bus.RdRF       = entryRd[headPtr];
            bus.WDataRF    = entryData[headPtr];
        end else if (bypass) begin
            bus.RegWriteRF = 1'b1;
            bus.RdRF       = bus.MduRd;
            bus.WDataRF    = bus.MduData;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_hit
            assign hit1Vec[gi] = entryValid[gi] && (entryRd[gi] == bus.Rs1Q);
            assign hit2Vec[gi] = entryValid[gi] && (entryRd[gi] == bus.Rs2Q);
        end
    endgenerate

    assign bus.PendHit1    = (bus.Rs1Q != 5'd0) && (|hit1Vec);
    assign bus.PendHit2    = (bus.Rs2Q != 5'd0) && (|hit2Vec);
    assign bus.MduReady    = mduReady;
    assign bus.BufCount    = count;
    assign bus.StarveStall = (age >= STARVE_AGE);

    // Drain and enqueue can only coincide when 0 < count < DEPTH, so head and tail never collide.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            headPtr    <= '0;
            tailPtr    <= '0;
            count      <= 3'd0;
            age        <= 3'd0;
            entryValid <= '0;
        end else begin
            if (drain) begin
                entryValid[headPtr] <= 1'b0;
                headPtr             <= nextPtr(headPtr);
            end
            if (enqueue) begin
                entryValid[tailPtr] <= 1'b1;
                tailPtr             <= nextPtr(tailPtr);
            end
            case ({enqueue, drain})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
            if (drain || (count == 3'd0)) begin
                age <= 3'd0;
            end else if (age != 3'd7) begin
                age <= age + 3'd1;
            end
        end
    end

    // Payload needs no reset: occupancy is tracked by entryValid and count.
    always_ff @(posedge clk) begin
        if (enqueue) begin
            entryRd[tailPtr]   <= bus.MduRd;
            entryData[tailPtr] <= bus.MduData;
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed, table-driven bench for wb_port_arbiter (DEPTH=2, STARVE_LIMIT=4): one table row
// per clock cycle, followed by a hand-written reset-during-operation sequence.
module tb_wb_port_arbiter;

    typedef struct {
        logic        rw;
        logic [4:0]  rdw;
        logic [31:0] resw;
        logic        mv;
        logic [4:0]  mrd;
        logic [31:0] md;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        ewr;
        logic [4:0]  erd;
        logic [31:0] ewd;
        logic        erdy;
        logic [2:0]  ecnt;
        logic        eph1;
        logic        eph2;
        logic        est;
    } vec_t;

    localparam int NVEC = 27;

    logic clk;
    logic reset;
    int   checks;
    int   failures;
    vec_t vecs [NVEC];

    wb_port_arbiter_if bus();

    wb_port_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(
        input logic rw, input logic [4:0] rdw, input logic [31:0] resw,
        input logic mv, input logic [4:0] mrd, input logic [31:0] md,
        input logic [4:0] rs1, input logic [4:0] rs2,
        input logic ewr, input logic [4:0] erd, input logic [31:0] ewd,
        input logic erdy, input logic [2:0] ecnt,
        input logic eph1, input logic eph2, input logic est);
        vec_t v;
        v.rw = rw;   v.rdw = rdw; v.resw = resw;
        v.mv = mv;   v.mrd = mrd; v.md = md;
        v.rs1 = rs1; v.rs2 = rs2;
        v.ewr = ewr; v.erd = erd; v.ewd = ewd;
        v.erdy = erdy; v.ecnt = ecnt;
        v.eph1 = eph1; v.eph2 = eph2; v.est = est;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rw, input logic [4:0] rdw, input logic [31:0] resw,
                         input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                         input logic [4:0] rs1, input logic [4:0] rs2);
        bus.RegWriteW = rw;
        bus.RdW       = rdw;
        bus.ResultW   = resw;
        bus.MduValid  = mv;
        bus.MduRd     = mrd;
        bus.MduData   = md;
        bus.Rs1Q      = rs1;
        bus.Rs2Q      = rs2;
    endtask

    task automatic chk_rf(input string tag, input logic wr, input logic [4:0] rd,
                          input logic [31:0] wd);
        chk({tag, ".RegWriteRF"}, {31'd0, bus.RegWriteRF}, {31'd0, wr});
        chk({tag, ".RdRF"},       {27'd0, bus.RdRF},       {27'd0, rd});
        chk({tag, ".WDataRF"},    bus.WDataRF,             wd);
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        //           rw rdw resw          mv mrd md            rs1 rs2 | wr rd  wd            rdy cnt ph1 ph2 st
        vecs[0]  = mk(0, 0, 32'h0,        0, 0,  32'h0,        0,  0,    0, 0,  32'h0,        1,  0,  0,  0,  0);
        vecs[1]  = mk(0, 0, 32'h0,        1, 5,  32'hDEADBEEF, 5,  0,    1, 5,  32'hDEADBEEF, 1,  0,  0,  0,  0);
        vecs[2]  = mk(0, 0, 32'h0,        0, 0,  32'h0,        0,  0,    0, 0,  32'h0,        1,  0,  0,  0,  0);
        vecs[3]  = mk(1, 3, 32'hDADADADA, 1, 7,  32'h11111111, 7,  0,    1, 3,  32'hDADADADA, 1,  0,  0,  0,  0);
        vecs[4]  = mk(1, 4, 32'h44444444, 0, 0,  32'h0,        7,  7,    1, 4,  32'h44444444, 1,  1,  1,  1,  0);
        vecs[5]  = mk(0, 0, 32'h0,        0, 0,  32'h0,        7,  0,    1, 7,  32'h11111111, 1,  1,  1,  0,  0);
        vecs[6]  = mk(1, 0, 32'h99999999, 0, 0,  32'h0,        0,  0,    0, 0,  32'h0,        1,  0,  0,  0,  0);
        vecs[7]  = mk(1, 1, 32'hA1,       1, 8,  32'h8,        0,  0,    1, 1,  32'hA1,       1,  0,  0,  0,  0);
        vecs[8]  = mk(1, 2, 32'hA2,       1, 9,  32'h9,        9,  8,    1, 2,  32'hA2,       1,  1,  0,  1,  0);
        vecs[9]  = mk(1, 3, 32'hA3,       1, 10, 32'h10,       9,  8,    1, 3,  32'hA3,       0,  2,  1,  1,  0);
        vecs[10] = mk(1, 3, 32'hA3,       1, 10, 32'h10,       0,  0,    1, 3,  32'hA3,       0,  2,  0,  0,  0);
        vecs[11] = mk(0, 0, 32'h0,        1, 10, 32'h10,       0,  0,    1, 8,  32'h8,        0,  2,  0,  0,  0);
        vecs[12] = mk(0, 0, 32'h0,        1, 10, 32'h10,       10, 0,    1, 9,  32'h9,        1,  1,  0,  0,  0);
        vecs[13] = mk(0, 0, 32'h0,        0, 0,  32'h0,        10, 0,    1, 10, 32'h10,       1,  1,  1,  0,  0);
        vecs[14] = mk(0, 0, 32'h0,        0, 0,  32'h0,        0,  0,    0, 0,  32'h0,        1,  0,  0,  0,  0);
        vecs[15] = mk(1, 1, 32'hB1,       1, 6,  32'h66,       0,  0,    1, 1,  32'hB1,       1,  0,  0,  0,  0);
        vecs[16] = mk(1, 1, 32'hB1,       0, 0,  32'h0,        6,  0,    1, 1,  32'hB1,       1,  1,  1,  0,  0);
        vecs[17] = mk(1, 1, 32'hB1,       0, 0,  32'h0,        6,  0,    1, 1,  32'hB1,       1,  1,  1,  0,  0);
        vecs[18] = mk(1, 1, 32'hB1,       0, 0,  32'h0,        6,  0,    1, 1,  32'hB1,       1,  1,  1,  0,  0);
        vecs[19] = mk(1, 1, 32'hB1,       0, 0,  32'h0,        6,  0,    1, 1,  32'hB1,       1,  1,  1,  0,  0);
        vecs[20] = mk(1, 1, 32'hB1,       0, 0,  32'h0,        6,  0,    1, 1,  32'hB1,       1,  1,  1,  0,  1);
        vecs[21] = mk(0, 0, 32'h0,        0, 0,  32'h0,        6,  0,    1, 6,  32'h66,       1,  1,  1,  0,  1);
        vecs[22] = mk(1, 1, 32'hB1,       0, 0,  32'h0,        6,  0,    1, 1,  32'hB1,       1,  0,  0,  0,  0);
        vecs[23] = mk(0, 0, 32'h0,        1, 0,  32'hFFFFFFFF, 0,  0,    0, 0,  32'h0,        1,  0,  0,  0,  0);
        vecs[24] = mk(0, 0, 32'h0,        0, 0,  32'h0,        0,  0,    0, 0,  32'h0,        1,  0,  0,  0,  0);
        vecs[25] = mk(1, 0, 32'h12345678, 1, 2,  32'h22,       0,  0,    1, 2,  32'h22,       1,  0,  0,  0,  0);
        vecs[26] = mk(0, 0, 32'h0,        0, 0,  32'h0,        0,  0,    0, 0,  32'h0,        1,  0,  0,  0,  0);

        // Reset state, with a live pipeline write visible through the port.
        reset = 1'b1;
        drive(1, 9, 32'h5A5A5A5A, 1, 4, 32'h1, 4, 4);
        #2;
        chk("rst.BufCount", {29'd0, bus.BufCount}, 32'd0);
        chk("rst.MduReady", {31'd0, bus.MduReady}, 32'd0);
        chk("rst.PendHit1", {31'd0, bus.PendHit1}, 32'd0);
        chk("rst.StarveStall", {31'd0, bus.StarveStall}, 32'd0);
        chk_rf("rst", 1, 9, 32'h5A5A5A5A);
        @(posedge clk); #1;
        chk("rst.BufCountEdge", {29'd0, bus.BufCount}, 32'd0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            @(posedge clk); #1;
            drive(vecs[i].rw, vecs[i].rdw, vecs[i].resw, vecs[i].mv, vecs[i].mrd,
                  vecs[i].md, vecs[i].rs1, vecs[i].rs2);
            #3;
            chk_rf($sformatf("v%0d", i), vecs[i].ewr, vecs[i].erd, vecs[i].ewd);
            chk($sformatf("v%0d.MduReady", i),    {31'd0, bus.MduReady},    {31'd0, vecs[i].erdy});
            chk($sformatf("v%0d.BufCount", i),    {29'd0, bus.BufCount},    {29'd0, vecs[i].ecnt});
            chk($sformatf("v%0d.PendHit1", i),    {31'd0, bus.PendHit1},    {31'd0, vecs[i].eph1});
            chk($sformatf("v%0d.PendHit2", i),    {31'd0, bus.PendHit2},    {31'd0, vecs[i].eph2});
            chk($sformatf("v%0d.StarveStall", i), {31'd0, bus.StarveStall}, {31'd0, vecs[i].est});
            $display("vec %0d: RegWriteRF=%0b RdRF=%0d WDataRF=%h BufCount=%0d", i,
                     bus.RegWriteRF, bus.RdRF, bus.WDataRF, bus.BufCount);
        end

        // Fill both entries behind pipeline writes, then reset mid-cycle.
        @(posedge clk); #1;
        drive(1, 1, 32'hC1, 1, 13, 32'hD, 0, 0);
        @(posedge clk); #1;
        drive(1, 2, 32'hC2, 1, 14, 32'hE, 0, 0);
        @(posedge clk); #1;
        drive(1, 3, 32'hC3, 0, 0, 0, 13, 14);
        #1;
        chk("full.BufCount", {29'd0, bus.BufCount}, 32'd2);
        chk("full.PendHit1", {31'd0, bus.PendHit1}, 32'd1);
        chk("full.PendHit2", {31'd0, bus.PendHit2}, 32'd1);
        #1;
        reset = 1'b1;
        #1;
        chk("midrst.BufCount", {29'd0, bus.BufCount}, 32'd0);
        chk("midrst.MduReady", {31'd0, bus.MduReady}, 32'd0);
        chk("midrst.PendHit1", {31'd0, bus.PendHit1}, 32'd0);
        chk("midrst.PendHit2", {31'd0, bus.PendHit2}, 32'd0);
        chk_rf("midrst", 1, 3, 32'hC3);
        drive(0, 0, 0, 0, 0, 0, 13, 14);
        #1;
        chk_rf("midrst.free", 0, 0, 32'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;

        // Release with an MDU offer pending: the first edge must accept it.
        reset = 1'b0;
        drive(1, 4, 32'hC4, 1, 15, 32'hF, 13, 14);
        #1;
        chk("rel.MduReady", {31'd0, bus.MduReady}, 32'd1);
        chk_rf("rel", 1, 4, 32'hC4);
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0, 0, 13, 15);
        #1;
        chk("rel.BufCount", {29'd0, bus.BufCount}, 32'd1);
        chk("rel.PendHit1", {31'd0, bus.PendHit1}, 32'd0);
        chk("rel.PendHit2", {31'd0, bus.PendHit2}, 32'd1);
        chk_rf("rel.drain", 1, 15, 32'hF);
        @(posedge clk); #1;
        #1;
        chk("rel.BufCountEnd", {29'd0, bus.BufCount}, 32'd0);
        chk_rf("rel.idle", 0, 0, 32'h0);
        $display("reset sequence: BufCount=%0d RegWriteRF=%0b", bus.BufCount, bus.RegWriteRF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
